// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: runtime-loadable pattern, overlap/non-overlap
// matching, valid qualification, Mealy match flag plus registered copy and saturating count.
module seq_detect_param #(
    parameter int               PAT_W   = 3,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(3'b101)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             out,
    output logic             out_r,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int                FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_r;
    logic              ovl_r;
    logic [PAT_W-2:0]  hist_r;
    logic [FILL_W-1:0] fill_r;

    logic [PAT_W-1:0]  window_s;
    logic              match_s;
    logic [PAT_W-1:0]  pat_nxt_s;
    logic              ovl_nxt_s;
    logic [PAT_W-2:0]  hist_nxt_s;
    logic [FILL_W-1:0] fill_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;

    // Match detection: current bit completes the window only once history is full.
    always_comb begin
        window_s = {hist_r, in};
        match_s  = rst & in_valid & ~cfg_load & (fill_r == FILL_MAX) & (window_s == pat_r);
        out      = match_s;
    end

    // Next-state for config, history and fill; a load discards the bit seen that cycle.
    always_comb begin
        pat_nxt_s  = pat_r;
        ovl_nxt_s  = ovl_r;
        hist_nxt_s = hist_r;
        fill_nxt_s = fill_r;
        if (cfg_load) begin
            pat_nxt_s  = cfg_pattern;
            ovl_nxt_s  = cfg_overlap;
            hist_nxt_s = '0;
            fill_nxt_s = '0;
        end else if (in_valid) begin
            hist_nxt_s = window_s[PAT_W-2:0];
            if (match_s && !ovl_r) begin
                fill_nxt_s = '0;
            end else if (fill_r != FILL_MAX) begin
                fill_nxt_s = fill_r + FILL_W'(1);
            end else begin
                fill_nxt_s = fill_r;
            end
        end else begin
            hist_nxt_s = hist_r;
            fill_nxt_s = fill_r;
        end
    end

    // Match counter next value: clear wins over a coincident match, then saturate.
    always_comb begin
        cnt_nxt_s = match_cnt;
        if (cnt_clr) begin
            cnt_nxt_s = '0;
        end else if (match_s && !(&match_cnt)) begin
            cnt_nxt_s = match_cnt + CNT_W'(1);
        end else begin
            cnt_nxt_s = match_cnt;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_r     <= RST_PAT;
            ovl_r     <= 1'b0;
            hist_r    <= '0;
            fill_r    <= '0;
            out_r     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            pat_r     <= pat_nxt_s;
            ovl_r     <= ovl_nxt_s;
            hist_r    <= hist_nxt_s;
            fill_r    <= fill_nxt_s;
            out_r     <= match_s;
            match_cnt <= cnt_nxt_s;
            cnt_sat   <= &cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (default and PAT_W=4/CNT_W=2) checked
// every cycle against a bit-history reference model, plus directed scenario checks.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       din, vld, load, ovl, clr;
    logic [2:0] pat0;
    logic [3:0] pat1;
    logic       out0, outr0, sat0, out1, outr1, sat1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(3), .CNT_W(8), .RST_PAT(3'b101)) dut0 (
        .clk(clk), .rst(rst), .in(din), .in_valid(vld), .cfg_load(load),
        .cfg_pattern(pat0), .cfg_overlap(ovl), .cnt_clr(clr),
        .out(out0), .out_r(outr0), .match_cnt(cnt0), .cnt_sat(sat0)
    );

    seq_detect_param #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1011)) dut1 (
        .clk(clk), .rst(rst), .in(din), .in_valid(vld), .cfg_load(load),
        .cfg_pattern(pat1), .cfg_overlap(ovl), .cnt_clr(clr),
        .out(out1), .out_r(outr1), .match_cnt(cnt1), .cnt_sat(sat1)
    );

    // Reference model: raw accepted-bit history, count of bits since last clear.
    int     W[2]    = '{3, 4};
    int     CMAX[2] = '{255, 3};
    int     RSTP[2] = '{5, 11};
    longint mh[2];
    int     mf[2];
    int     mp[2];
    bit     mo[2];
    int     mc[2];
    bit     eo[2];
    bit     eor[2];
    bit     o0, o1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mh[i] = 0; mf[i] = 0; mp[i] = RSTP[i]; mo[i] = 1'b0; mc[i] = 0; eor[i] = 1'b0;
        end
    endtask

    function automatic bit model_match(input int i);
        longint w;
        w = ((mh[i] << 1) | longint'(din)) & ((64'd1 << W[i]) - 64'd1);
        return rst && vld && !load && (mf[i] >= W[i] - 1) && (w == longint'(mp[i]));
    endfunction

    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            if (clr) mc[i] = 0;
            else if (eo[i] && mc[i] < CMAX[i]) mc[i] = mc[i] + 1;
            eor[i] = eo[i];
            if (load) begin
                mp[i] = (i == 0) ? int'(pat0) : int'(pat1);
                mo[i] = ovl; mh[i] = 0; mf[i] = 0;
            end else if (vld) begin
                mh[i] = (mh[i] << 1) | longint'(din);
                if (eo[i] && !mo[i]) mf[i] = 0;
                else mf[i] = mf[i] + 1;
            end
        end
    endtask

    // One clock: inputs already driven at the falling edge.
    task automatic cycle();
        #1;
        if (!rst) begin
            model_reset();
            check("rst_cnt0", cnt0, 0);  check("rst_cnt1", cnt1, 0);
            check("rst_outr0", outr0, 0); check("rst_sat1", sat1, 0);
        end
        for (int i = 0; i < 2; i++) eo[i] = model_match(i);
        o0 = out0; o1 = out1;
        check("out0", out0, eo[0]);
        check("out1", out1, eo[1]);
        @(posedge clk);
        if (rst) model_clock();
        #1;
        check("out_r0", outr0, eor[0]); check("out_r1", outr1, eor[1]);
        check("cnt0", cnt0, mc[0]);     check("cnt1", cnt1, mc[1]);
        check("sat0", sat0, mc[0] == CMAX[0]);
        check("sat1", sat1, mc[1] == CMAX[1]);
        @(negedge clk);
    endtask

    task automatic bit_in(input bit b, input bit e0, input string tag);
        din = b; vld = 1'b1; load = 1'b0; clr = 1'b0;
        cycle();
        check(tag, o0, e0);
    endtask

    task automatic do_load(input logic [2:0] p0, input logic [3:0] p1, input bit ov, input bit cl);
        load = 1'b1; vld = 1'b0; din = 1'b0; pat0 = p0; pat1 = p1; ovl = ov; clr = cl;
        cycle();
        load = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; vld = 1'b0; load = 1'b0; ovl = 1'b0; clr = 1'b0;
        pat0 = 3'b000; pat1 = 4'b0000;
        #1 rst = 1'b0;
        model_reset();
        #2;
        check("reset_out0", out0, 0);  check("reset_outr0", outr0, 0);
        check("reset_cnt0", cnt0, 0);  check("reset_sat0", sat0, 0);
        check("reset_out1", out1, 0);  check("reset_cnt1", cnt1, 0);
        @(negedge clk);
        rst = 1'b1;

        // Default 101, non-overlapping
        bit_in(1'b1, 1'b0, "t1_b1"); bit_in(1'b0, 1'b0, "t1_b2"); bit_in(1'b1, 1'b1, "t1_b3");
        check("t1_outr", outr0, 1);
        bit_in(1'b0, 1'b0, "t1_b4"); bit_in(1'b1, 1'b0, "t1_b5");
        check("t1_cnt", cnt0, 1);

        // Overlapping 101
        do_load(3'b101, 4'b1010, 1'b1, 1'b1);
        bit_in(1'b1, 1'b0, "t2_b1"); bit_in(1'b0, 1'b0, "t2_b2"); bit_in(1'b1, 1'b1, "t2_b3");
        bit_in(1'b0, 1'b0, "t2_b4"); bit_in(1'b1, 1'b1, "t2_b5");
        check("t2_cnt", cnt0, 2);

        // Invalid cycles hold history
        do_load(3'b101, 4'b1010, 1'b1, 1'b0);
        bit_in(1'b1, 1'b0, "t3_b1"); bit_in(1'b0, 1'b0, "t3_b2");
        for (int k = 0; k < 4; k++) begin
            vld = 1'b0; din = k[0];
            cycle();
            check("t3_invalid", o0, 0);
        end
        bit_in(1'b1, 1'b1, "t3_b3");
        check("t3_cnt", cnt0, 3);

        // Reset mid-pattern
        do_load(3'b101, 4'b1010, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, "t4_b1"); bit_in(1'b0, 1'b0, "t4_b2");
        rst = 1'b0; din = 1'b1; vld = 1'b1;
        cycle();
        check("t4_rst_out", o0, 0);
        rst = 1'b1;
        bit_in(1'b1, 1'b0, "t4_b3"); bit_in(1'b0, 1'b0, "t4_b4"); bit_in(1'b1, 1'b1, "t4_b5");

        // All-ones overlapping, 2-bit counter saturation and clear priority
        do_load(3'b111, 4'b1111, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            bit_in(1'b1, k >= 3, "t5_out0");
            check("t5_out1", o1, k >= 4);
        end
        check("t5_cnt1", cnt1, 3);
        check("t5_sat1", sat1, 1);
        din = 1'b1; vld = 1'b1; clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("t5_clr_out1", o1, 1);
        check("t5_clr_cnt1", cnt1, 0);
        check("t5_clr_sat1", sat1, 0);

        // Load discards that cycle's bit
        do_load(3'b101, 4'b1010, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, "t6_b1"); bit_in(1'b0, 1'b0, "t6_b2");
        load = 1'b1; vld = 1'b1; din = 1'b1;
        cycle();
        load = 1'b0;
        check("t6_load_out", o0, 0);
        bit_in(1'b1, 1'b0, "t6_b3"); bit_in(1'b0, 1'b0, "t6_b4"); bit_in(1'b1, 1'b1, "t6_b5");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 99) != 0);
            din  = 1'($urandom);
            vld  = ($urandom_range(0, 3) != 0);
            load = ($urandom_range(0, 31) == 0);
            clr  = ($urandom_range(0, 15) == 0);
            ovl  = 1'($urandom);
            pat0 = 3'($urandom);
            pat1 = 4'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
